con_5x5: RTL and testbench

Streaming 3×3 convolution engine. It loads a 3×3 kernel and a 7×7 image over one 16-bit input port, in a fixed boustrophedon window order. It emits the 25 valid-region outputs (5×5) as single-cycle pulses. It sits between a word-serial data source and a result consumer, with no back-pressure.

---
 rtl/con_5x5_pkg.sv | 51 +++++
 rtl/con_5x5_mac9.sv | 28 ++
 rtl/con_5x5.sv | 112 +++++++++++
 tb/tb_con_5x5.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/con_5x5_pkg.sv
// Shared definitions for the con_5x5 streaming 3x3 convolution engine.
// Holds the data width, the frame geometry constants, the tap array types and
// the shift-mode decoder that maps a word index onto the window update.
package con_5x5_pkg;

  localparam int DATA_W = 16;

  typedef logic [DATA_W-1:0] word_t;
  // Tap r*3+c holds row r, column c (0-based) of a 3x3 kernel or window.
  typedef word_t [8:0] taps_t;

  localparam logic [6:0] KERNEL_WORDS  = 7'd9;
  localparam logic [6:0] FRAME_WORDS   = 7'd90;
  localparam logic [6:0] LAST_IDX      = 7'd89;
  localparam logic [6:0] FIRST_OUT_IDX = 7'd17;
  localparam logic [6:0] BAND1_START   = 7'd9;
  localparam logic [6:0] BAND2_START   = 7'd30;
  localparam logic [6:0] BAND3_START   = 7'd45;
  localparam logic [6:0] BAND4_START   = 7'd60;
  localparam logic [6:0] BAND5_START   = 7'd75;

  typedef enum logic [1:0] {
    LOAD_K,
    SHIFT_LEFT_IN_RIGHT,
    SHIFT_RIGHT_IN_LEFT,
    SHIFT_UP_IN_BOTTOM
  } shift_mode_e;

  // Bands 2..5 open with one row triple entering at the bottom; after that,
  // bands 2 and 4 walk leftwards (columns enter at the left) and bands 3 and 5
  // walk rightwards (columns enter at the right). Band starts sit on triple
  // boundaries, so "first triple" is simply the first three words of a band.
  function automatic shift_mode_e decode_mode(input logic [6:0] i);
    shift_mode_e m;
    if (i < BAND1_START)
      m = LOAD_K;
    else if (i < BAND2_START)
      m = SHIFT_LEFT_IN_RIGHT;
    else if ((i < BAND2_START + 7'd3) ||
             (i >= BAND3_START && i < BAND3_START + 7'd3) ||
             (i >= BAND4_START && i < BAND4_START + 7'd3) ||
             (i >= BAND5_START && i < BAND5_START + 7'd3))
      m = SHIFT_UP_IN_BOTTOM;
    else if ((i < BAND3_START) || (i >= BAND4_START && i < BAND5_START))
      m = SHIFT_RIGHT_IN_LEFT;
    else
      m = SHIFT_LEFT_IN_RIGHT;
    return m;
  endfunction

endpackage

// File: rtl/con_5x5_mac9.sv
// con_mac9: combinational 9-tap multiply-accumulate.
// Ports:
//   kernel  - 9 coefficients, tap r*3+c
//   window  - 9 pixels, tap r*3+c
//   result  - low DATA_W bits of sum(kernel[t] * window[t])
// Products and the sum are carried at full width; only the low bits leave.
module con_mac9
  import con_5x5_pkg::*;
(
  input  taps_t kernel,
  input  taps_t window,
  output word_t result
);

  localparam int ACC_W = 2 * DATA_W + 4;

  logic [ACC_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int t = 0; t < 9; t++) begin
      acc = acc + (ACC_W'(kernel[t]) * ACC_W'(window[t]));
    end
  end

  assign result = acc[DATA_W-1:0];

endmodule

// File: rtl/con_5x5.sv
// con_5x5: streaming 3x3 convolution over a 7x7 image, 25 outputs per frame.
// Ports:
//   clk, rst_n - rising-edge clock, asynchronous active-low reset
//   ena        - frame enable; high for the 90-word frame, low ends/aborts it
//   data       - input word (9 kernel words, then 81 window-stream words)
//   valid      - one-cycle pulse, result holds a new convolution output
//   finish     - one-cycle pulse alongside the 25th valid of a frame
//   result     - convolution output, held until the next valid
// Handshake: there is no ready; every cycle with ena=1 consumes one data word,
// and every valid pulse must be taken by the consumer in that cycle.
module con_5x5
  import con_5x5_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              finish,
  output logic [DATA_W-1:0] result
);

  logic [6:0]  idx;
  logic [1:0]  ph;         // position within the current triple
  word_t [1:0] stage;      // first two words of a triple, applied on the third
  taps_t       kernel;
  taps_t       win;
  taps_t       win_next;
  word_t [2:0] col;        // the complete incoming triple, element 0 first
  shift_mode_e mode;
  logic        pend;       // a window completed on the previous edge
  logic        pend_last;  // ... and it was the frame's final window
  word_t       mac_out;

  assign mode = decode_mode(idx);
  assign col  = {data, stage[1], stage[0]};

  // Whole-window update for the triple-final word. Columns arrive top to
  // bottom; the bottom-entering row arrives left to right.
  always_comb begin
    win_next = win;
    for (int r = 0; r < 3; r++) begin
      case (mode)
        SHIFT_LEFT_IN_RIGHT: begin
          win_next[3*r]   = win[3*r+1];
          win_next[3*r+1] = win[3*r+2];
          win_next[3*r+2] = col[r];
        end
        SHIFT_RIGHT_IN_LEFT: begin
          win_next[3*r+2] = win[3*r+1];
          win_next[3*r+1] = win[3*r];
          win_next[3*r]   = col[r];
        end
        SHIFT_UP_IN_BOTTOM: begin
          win_next[r]     = win[r+3];
          win_next[r+3]   = win[r+6];
          win_next[r+6]   = col[r];
        end
        default: ;
      endcase
    end
  end

  con_mac9 u_mac (
    .kernel (kernel),
    .window (win),
    .result (mac_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      ph        <= '0;
      stage     <= '0;
      kernel    <= '0;
      win       <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      valid     <= 1'b0;
      finish    <= 1'b0;
      result    <= '0;
    end else begin
      // Output stage runs regardless of ena so a triggered output completes.
      valid     <= pend;
      finish    <= pend_last;
      if (pend) result <= mac_out;
      pend      <= 1'b0;
      pend_last <= 1'b0;

      if (!ena) begin
        idx <= '0;
        ph  <= '0;
      end else begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 7'd1;
        if (mode == LOAD_K) begin
          kernel[idx[3:0]] <= data;
          ph               <= '0;
        end else if (ph == 2'd2) begin
          win       <= win_next;
          ph        <= '0;
          // The first two column triples only prime the window.
          pend      <= (idx >= FIRST_OUT_IDX);
          pend_last <= (idx == LAST_IDX);
        end else begin
          stage[ph[0]] <= data;
          ph           <= ph + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_con_5x5.sv
module tb_con_5x5;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [15:0] data;
  logic        valid;
  logic        finish;
  logic [15:0] result;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];
  logic        exp_fin_q[$];

  logic [15:0] kern  [9];
  logic [15:0] img   [7][7];
  logic [15:0] words [90];

  con_5x5 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .data   (data),
    .valid  (valid),
    .finish (finish),
    .result (result)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  // ---------------- comparison helper ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got result 0x%04h with nothing expected", result);
        end else begin
          logic [15:0] e;
          logic        f;
          e = exp_q.pop_front();
          f = exp_fin_q.pop_front();
          check("result", result, e);
          check("finish_with_valid", {15'd0, finish}, {15'd0, f});
        end
      end else if (finish) begin
        check("finish_without_valid", {15'd0, finish}, 16'd0);
      end
    end
  end

  // ---------------- stimulus setup ----------------
  // 0: all weights 1, all pixels 1
  // 1: centre weight 1, pixel(r,c) = 16r+c (1-based)
  // 2: all weights 0xFFFF, all pixels 1
  task automatic load_pattern(input int pat);
    for (int i = 0; i < 9; i++) begin
      case (pat)
        0:       kern[i] = 16'h0001;
        1:       kern[i] = (i == 4) ? 16'h0001 : 16'h0000;
        default: kern[i] = 16'hFFFF;
      endcase
    end
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        img[r][c] = (pat == 1) ? 16'((r + 1) * 16 + (c + 1)) : 16'h0001;
    build_words();
  endtask

  // Frame word order: kernel row-major, then the boustrophedon band stream.
  // Indices below are 1-based row/column numbers, mapped onto img[][].
  task automatic build_words();
    int n;
    n = 0;
    for (int i = 0; i < 9; i++) begin words[n] = kern[i]; n++; end
    for (int c = 1; c <= 7; c++)
      for (int r = 1; r <= 3; r++) begin words[n] = img[r-1][c-1]; n++; end
    for (int b = 2; b <= 5; b++) begin
      if (b % 2 == 0) begin
        for (int c = 5; c <= 7; c++) begin words[n] = img[b+1][c-1]; n++; end
        for (int c = 4; c >= 1; c--)
          for (int r = b; r <= b + 2; r++) begin words[n] = img[r-1][c-1]; n++; end
      end else begin
        for (int c = 1; c <= 3; c++) begin words[n] = img[b+1][c-1]; n++; end
        for (int c = 4; c <= 7; c++)
          for (int r = b; r <= b + 2; r++) begin words[n] = img[r-1][c-1]; n++; end
      end
    end
  endtask

  // Hand-derived expectations for the first cnt outputs of a pattern.
  task automatic expect_outputs(input int pat, input int cnt);
    for (int n = 0; n < cnt; n++) begin
      int row, col;
      logic [15:0] v;
      row = n / 5;
      col = (row % 2 == 0) ? (n % 5) : (4 - n % 5);
      case (pat)
        0:       v = 16'h0009;
        1:       v = 16'((row + 2) * 16 + (col + 2));
        default: v = 16'hFFF7;
      endcase
      exp_q.push_back(v);
      exp_fin_q.push_back(n == 24);
    end
  endtask

  // ---------------- driver ----------------
  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      ena  = 1'b0;
      data = 16'h0000;
    end
  endtask

  // Sends the first n words of the frame. lat_chk checks the first-output
  // latency around word idx 17; rst_mid pulses rst_n right after the last word.
  task automatic run_frame(input int n, input bit lat_chk, input bit rst_mid);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (lat_chk && k == 18) check("valid_at_capture_edge", {15'd0, valid}, 16'd0);
      if (lat_chk && k == 19) check("valid_one_after_word17", {15'd0, valid}, 16'd1);
      ena  = 1'b1;
      data = words[k];
    end
    if (rst_mid) begin
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      ena   = 1'b0;
      data  = 16'h0000;
      #1;
      check("reset_mid_valid",  {15'd0, valid},  16'd0);
      check("reset_mid_finish", {15'd0, finish}, 16'd0);
      check("reset_mid_result", result, 16'h0000);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
    end else begin
      @(posedge clk);
      #1;
      ena  = 1'b0;
      data = 16'h0000;
    end
    idle(4);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0;
    ena   = 1'b0;
    data  = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid",  {15'd0, valid},  16'd0);
    check("reset_finish", {15'd0, finish}, 16'd0);
    check("reset_result", result, 16'h0000);
    rst_n = 1'b1;
    idle(2);

    load_pattern(0); expect_outputs(0, 25); run_frame(90, 1'b0, 1'b0);
    load_pattern(1); expect_outputs(1, 25); run_frame(90, 1'b0, 1'b0);
    load_pattern(2); expect_outputs(2, 25); run_frame(90, 1'b0, 1'b0);

    // back-to-back frames, 5-cycle gap (run_frame already idles 4 + 1 ena-low edge)
    load_pattern(1);
    expect_outputs(1, 25);
    @(posedge clk); #1; ena = 1'b0;
    for (int k = 0; k < 90; k++) begin
      @(posedge clk); #1; ena = 1'b1; data = words[k];
    end
    idle(5);
    expect_outputs(1, 25);
    run_frame(90, 1'b1, 1'b0);

    // abort after 40 words, then a full frame
    expect_outputs(1, 8);
    run_frame(40, 1'b0, 1'b0);
    expect_outputs(1, 25);
    run_frame(90, 1'b0, 1'b0);

    // reset during word idx 49, then a full frame
    expect_outputs(1, 11);
    run_frame(50, 1'b0, 1'b1);
    load_pattern(0);
    expect_outputs(0, 25);
    run_frame(90, 1'b0, 1'b0);

    idle(5);
    check("leftover_expected", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
